// File: rtl/msg_serializer.sv
// Buffers up to two parallel messages with their lost flag and replays each one as a byte
// stream (byte 0 first) with last/lost sidebands; optionally trims trailing zero bytes.
module msg_serializer #(
  parameter int MSG_BYTES  = 37,
  parameter bit TRIM_ZEROS = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [0:MSG_BYTES*8-1] msgIn,
  input  logic                   msgIn_lost,
  input  logic                   msgIn_val,
  output logic                   msgIn_ready,
  output logic [7:0]             dataOut,
  output logic                   dataOut_val,
  input  logic                   dataOut_ready,
  output logic                   dataOut_last,
  output logic                   dataOut_lost,
  output logic [CNT_W-1:0]       lostCount,
  output logic [CNT_W-1:0]       msgCount,
  output logic [1:0]             stateDbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid holds its payload stable until that edge, ready never depends on valid.

  localparam int LEN_W = 6;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2} state_t;

  state_t                 state;
  logic [0:MSG_BYTES*8-1] memMsg [2];
  logic                   memLost [2];
  logic [LEN_W-1:0]       memLen [2];
  logic                   wrPtr, rdPtr;
  logic [1:0]             occ, occNext;
  logic [LEN_W-1:0]       idx, inLen, headLen, selIdx;
  logic [7:0]             selByte;
  logic                   accept, sendFire, popHit;

  assign stateDbg = state;
  assign accept   = msgIn_val & msgIn_ready;
  assign headLen  = memLen[rdPtr];
  assign sendFire = (state == SEND) & dataOut_val & dataOut_ready;
  assign popHit   = sendFire & (idx == headLen - LEN_W'(1));
  assign occNext  = occ + {1'b0, accept} - {1'b0, popHit};

  // Length is one past the highest nonzero byte; an all-zero message still sends one byte.
  always_comb begin
    inLen = LEN_W'(1);
    for (int k = 0; k < MSG_BYTES; k++) begin
      if (msgIn[8*k +: 8] != 8'h00) inLen = LEN_W'(k + 1);
    end
    if (!TRIM_ZEROS) inLen = LEN_W'(MSG_BYTES);
  end

  // LOAD fetches byte 0; SEND pre-fetches the byte after the one being presented.
  always_comb begin
    selIdx  = (state == SEND) ? idx + LEN_W'(1) : '0;
    selByte = memMsg[rdPtr][8*int'(selIdx) +: 8];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      memMsg[wrPtr]  <= msgIn;
      memLost[wrPtr] <= msgIn_lost;
      memLen[wrPtr]  <= inLen;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wrPtr        <= 1'b0;
      rdPtr        <= 1'b0;
      occ          <= 2'd0;
      msgIn_ready  <= 1'b0;
      idx          <= '0;
      dataOut      <= 8'h00;
      dataOut_val  <= 1'b0;
      dataOut_last <= 1'b0;
      dataOut_lost <= 1'b0;
      lostCount    <= '0;
      msgCount     <= '0;
    end else begin
      occ         <= occNext;
      // A pop while full does not reopen the input until the following cycle.
      msgIn_ready <= (occNext != 2'd2);
      if (accept) begin
        wrPtr    <= ~wrPtr;
        msgCount <= msgCount + CNT_W'(1);
        if (msgIn_lost && (lostCount != '1)) lostCount <= lostCount + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (occ != 2'd0) state <= LOAD;
        end
        LOAD: begin
          dataOut      <= selByte;
          idx          <= '0;
          dataOut_val  <= 1'b1;
          dataOut_last <= (headLen == LEN_W'(1));
          dataOut_lost <= memLost[rdPtr];
          state        <= SEND;
        end
        SEND: begin
          if (popHit) begin
            rdPtr        <= ~rdPtr;
            dataOut      <= 8'h00;
            dataOut_val  <= 1'b0;
            dataOut_last <= 1'b0;
            dataOut_lost <= 1'b0;
            state        <= (occNext != 2'd0) ? LOAD : IDLE;
          end else if (sendFire) begin
            idx          <= idx + LEN_W'(1);
            dataOut      <= selByte;
            dataOut_last <= (idx + LEN_W'(1) == headLen - LEN_W'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_serializer.sv
// Bench for msg_serializer: a trimming instance (dut) and an untrimmed 2-bit-counter
// instance (dutB), each with an expected-byte queue checked as bytes leave the DUT.
module tb_msg_serializer;

  localparam int MW = 296;

  typedef struct {
    logic       lost;
    logic       zero;
    int         hi;
    logic [7:0] fill;
    logic       holes;
    int         expLen;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [0:MW-1] msgIn;
  logic          msgIn_lost, msgIn_val, msgIn_ready;
  logic [7:0]    dataOut;
  logic          dataOut_val, dataOut_ready, dataOut_last, dataOut_lost;
  logic [15:0]   lostCount, msgCount;
  logic [1:0]    stateDbg;

  logic [0:MW-1] bMsg;
  logic          bLostIn, bVal, bReadyOut;
  logic [7:0]    bData;
  logic          bDVal, bDReady, bLast, bLost;
  logic [1:0]    bLostCnt, bMsgCnt, bState;

  int            checks = 0;
  int            errors = 0;
  int            aMode  = 0;
  int            expMsg = 0, expLost = 0, bExpMsg = 0, bExpLost = 0;
  logic [9:0]    exp_q[$];
  logic [9:0]    bexp_q[$];
  vec_t          vecs[6];

  always #5 clk = ~clk;

  msg_serializer dut (
    .clk(clk), .reset(reset), .msgIn(msgIn), .msgIn_lost(msgIn_lost), .msgIn_val(msgIn_val),
    .msgIn_ready(msgIn_ready), .dataOut(dataOut), .dataOut_val(dataOut_val),
    .dataOut_ready(dataOut_ready), .dataOut_last(dataOut_last), .dataOut_lost(dataOut_lost),
    .lostCount(lostCount), .msgCount(msgCount), .stateDbg(stateDbg)
  );

  msg_serializer #(.MSG_BYTES(37), .TRIM_ZEROS(1'b0), .CNT_W(2)) dutB (
    .clk(clk), .reset(reset), .msgIn(bMsg), .msgIn_lost(bLostIn), .msgIn_val(bVal),
    .msgIn_ready(bReadyOut), .dataOut(bData), .dataOut_val(bDVal),
    .dataOut_ready(bDReady), .dataOut_last(bLast), .dataOut_lost(bLost),
    .lostCount(bLostCnt), .msgCount(bMsgCnt), .stateDbg(bState)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  function automatic logic [0:MW-1] build(input vec_t v);
    logic [0:MW-1] m;
    m = '0;
    if (!v.zero) begin
      for (int k = 0; k <= v.hi; k++) begin
        if (v.holes && (k % 2 == 1) && (k != v.hi)) m[8*k +: 8] = 8'h00;
        else m[8*k +: 8] = v.fill + 8'(k);
      end
    end
    return m;
  endfunction

  task automatic push_exp(input bit sideB, input logic [0:MW-1] m, input logic lost, input int len);
    for (int k = 0; k < len; k++) begin
      if (sideB) bexp_q.push_back({k == len - 1, lost, m[8*k +: 8]});
      else       exp_q.push_back({k == len - 1, lost, m[8*k +: 8]});
    end
  endtask

  task automatic drive_a(input logic [0:MW-1] m, input logic lost, input int len);
    bit ok = 0;
    msgIn = m; msgIn_lost = lost; msgIn_val = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (msgIn_ready) begin ok = 1; break; end
    end
    if (!ok) fail_now("a_accept_timeout");
    else begin
      push_exp(0, m, lost, len);
      expMsg++;
      if (lost && expLost < 65535) expLost++;
    end
    @(posedge clk); #1;
    msgIn_val = 1'b0;
  endtask

  task automatic drive_b(input logic [0:MW-1] m, input logic lost);
    bit ok = 0;
    bMsg = m; bLostIn = lost; bVal = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bReadyOut) begin ok = 1; break; end
    end
    if (!ok) fail_now("b_accept_timeout");
    else begin
      push_exp(1, m, lost, 37);
      bExpMsg = (bExpMsg + 1) % 4;
      if (lost && bExpLost < 3) bExpLost++;
    end
    @(posedge clk); #1;
    bVal = 1'b0;
  endtask

  task automatic wait_drain_a();
    bit ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !dataOut_val) begin ok = 1; break; end
    end
    if (!ok) fail_now("a_drain_timeout");
  endtask

  task automatic wait_drain_b();
    bit ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (bexp_q.size() == 0 && !bDVal) begin ok = 1; break; end
    end
    if (!ok) fail_now("b_drain_timeout");
  endtask

  // Downstream ready for dut: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    dataOut_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (aMode)
        1:       dataOut_ready = 1'($urandom_range(0, 1));
        2:       dataOut_ready = 1'b0;
        default: dataOut_ready = 1'b1;
      endcase
    end
  end

  initial begin
    bDReady = 1'b0;
    forever begin
      @(posedge clk); #1;
      bDReady = ~bDReady;
    end
  end

  logic       aHeld = 1'b0, bHeld = 1'b0;
  logic [9:0] aHeldVal, bHeldVal;

  always @(negedge clk) begin
    if (reset) aHeld = 1'b0;
    else begin
      if (aHeld && dataOut_val) chk("a_stable", 32'({dataOut_last, dataOut_lost, dataOut}), 32'(aHeldVal));
      if (dataOut_val && dataOut_ready) begin
        if (exp_q.size() == 0) chk("a_extra_byte", 32'({dataOut_last, dataOut_lost, dataOut}), 32'h400);
        else chk("a_byte", 32'({dataOut_last, dataOut_lost, dataOut}), 32'(exp_q.pop_front()));
      end else if (!dataOut_val) chk("a_idle_zero", 32'({dataOut_last, dataOut_lost, dataOut}), 32'h0);
      aHeld    = dataOut_val & ~dataOut_ready;
      aHeldVal = {dataOut_last, dataOut_lost, dataOut};
    end
  end

  always @(negedge clk) begin
    if (reset) bHeld = 1'b0;
    else begin
      if (bHeld && bDVal) chk("b_stable", 32'({bLast, bLost, bData}), 32'(bHeldVal));
      if (bDVal && bDReady) begin
        if (bexp_q.size() == 0) chk("b_extra_byte", 32'({bLast, bLost, bData}), 32'h400);
        else chk("b_byte", 32'({bLast, bLost, bData}), 32'(bexp_q.pop_front()));
      end
      bHeld    = bDVal & ~bDReady;
      bHeldVal = {bLast, bLost, bData};
    end
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4,  8'h01, 1'b0, 5};
    vecs[1] = '{1'b1, 1'b1, 0,  8'h00, 1'b0, 1};
    vecs[2] = '{1'b0, 1'b0, 36, 8'h10, 1'b1, 37};
    vecs[3] = '{1'b1, 1'b0, 0,  8'hAA, 1'b0, 1};
    vecs[4] = '{1'b0, 1'b0, 20, 8'h30, 1'b1, 21};
    vecs[5] = '{1'b1, 1'b0, 35, 8'hC0, 1'b0, 36};

    reset = 1'b1;
    msgIn = '0; msgIn_lost = 1'b0; msgIn_val = 1'b0;
    bMsg = '0; bLostIn = 1'b0; bVal = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_val", 32'(dataOut_val), 32'h0);
    chk("rst_ready", 32'(msgIn_ready), 32'h0);
    chk("rst_msgcount", 32'(msgCount), 32'h0);
    chk("rst_lostcount", 32'(lostCount), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(msgIn_ready), 32'h1);

    // First byte appears two edges after the accepting edge.
    drive_a(build(vecs[0]), vecs[0].lost, vecs[0].expLen);
    chk("lat_edge_n", 32'(dataOut_val), 32'h0);
    @(posedge clk); #1;
    chk("lat_edge_n1", 32'(dataOut_val), 32'h0);
    @(posedge clk); #1;
    chk("lat_edge_n2", 32'(dataOut_val), 32'h1);
    chk("lat_byte0", 32'(dataOut), 32'h01);
    wait_drain_a();

    for (int pass = 0; pass < 2; pass++) begin
      aMode = pass;
      for (int i = 0; i < 6; i++) drive_a(build(vecs[i]), vecs[i].lost, vecs[i].expLen);
      wait_drain_a();
      chk("tbl_msgcount", 32'(msgCount), 32'(expMsg));
      chk("tbl_lostcount", 32'(lostCount), 32'(expLost));
    end
    aMode = 0;

    // Stalled output: two messages fill the buffer, the third waits.
    aMode = 2;
    @(posedge clk); #1;
    drive_a(build(vecs[0]), vecs[0].lost, vecs[0].expLen);
    drive_a(build(vecs[3]), vecs[3].lost, vecs[3].expLen);
    chk("full_ready", 32'(msgIn_ready), 32'h0);
    fork
      drive_a(build(vecs[4]), vecs[4].lost, vecs[4].expLen);
      begin
        repeat (8) @(posedge clk);
        #1 chk("full_hold", 32'(msgIn_ready), 32'h0);
        aMode = 0;
      end
    join
    wait_drain_a();
    chk("full_msgcount", 32'(msgCount), 32'(expMsg));

    // Asynchronous reset in the middle of a long message.
    drive_a(build(vecs[2]), vecs[2].lost, vecs[2].expLen);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_val", 32'(dataOut_val), 32'h0);
    chk("midrst_ready", 32'(msgIn_ready), 32'h0);
    chk("midrst_msgcount", 32'(msgCount), 32'h0);
    chk("midrst_lostcount", 32'(lostCount), 32'h0);
    chk("midrst_data", 32'(dataOut), 32'h0);
    exp_q.delete();
    expMsg = 0; expLost = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    drive_a(build(vecs[1]), vecs[1].lost, vecs[1].expLen);
    wait_drain_a();
    chk("zero_lostcount", 32'(lostCount), 32'h1);
    chk("zero_msgcount", 32'(msgCount), 32'h1);

    // Untrimmed instance with 2-bit counters and toggling downstream ready.
    for (int i = 0; i < 5; i++) drive_b('0, 1'b1);
    wait_drain_b();
    chk("sat_lostcount", 32'(bLostCnt), 32'(bExpLost));
    chk("wrap_msgcount", 32'(bMsgCnt), 32'(bExpMsg));
    drive_b(build('{1'b0, 1'b0, 9, 8'h01, 1'b0, 10}), 1'b0);
    wait_drain_b();
    chk("notrim_msgcount", 32'(bMsgCnt), 32'(bExpMsg));
    chk("notrim_lostcount", 32'(bLostCnt), 32'(bExpLost));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
